// File: rtl/branch_predictor_ctrl.sv
// Bimodal direction predictor with in-order branch queue; prediction is same-cycle, flush/redirect 1 cycle after resolve.
// Backpressure: fetchStall when the queue is full and no slot frees this cycle; resolves are never stalled.
module branch_predictor_ctrl #(
  parameter int IDX_BITS = 6,
  parameter int DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetchValid,
  input  logic [31:0] fetchPC,
  input  logic [31:0] fetchInstr,
  output logic        predictTaken,
  output logic        fetchStall,
  input  logic        resolveValid,
  input  logic        resolveTaken,
  input  logic [31:0] resolveTargetPC,
  output logic        flush,
  output logic [31:0] redirectPC
);

  localparam int PTR_BITS = $clog2(DEPTH);
  localparam int ENTRIES  = 1 << IDX_BITS;
  localparam logic [PTR_BITS:0]   CNT_FULL = (PTR_BITS + 1)'(DEPTH);
  localparam logic [PTR_BITS:0]   CNT_ONE  = (PTR_BITS + 1)'(1);
  localparam logic [PTR_BITS-1:0] PTR_ONE  = PTR_BITS'(1);

  typedef struct packed {
    logic [31:0]         pc;
    logic [IDX_BITS-1:0] idx;
    logic                pred;
  } entry_t;

  logic [1:0]          bht [ENTRIES];
  entry_t              q   [DEPTH];
  logic [PTR_BITS-1:0] rd_ptr, wr_ptr;
  logic [PTR_BITS:0]   count;

  logic                is_branch, full, empty, push, pop, mispredict;
  logic [IDX_BITS-1:0] fetch_idx;
  logic [1:0]          head_ctr, head_ctr_nxt;
  logic [31:0]         redirect_nxt;
  entry_t              head;
  logic                unused_bits;

  assign unused_bits = ^{fetchInstr[31:7], fetchPC[31:IDX_BITS+2], fetchPC[1:0]};

  assign is_branch    = fetchValid & (fetchInstr[6:0] == 7'b1100011);
  assign fetch_idx    = fetchPC[IDX_BITS+1:2];
  assign predictTaken = is_branch & bht[fetch_idx][1];

  assign full       = (count == CNT_FULL);
  assign empty      = (count == '0);
  assign pop        = resolveValid & ~empty;
  assign fetchStall = is_branch & full & ~pop;
  assign push       = is_branch & ~fetchStall & ~flush;

  assign head         = q[rd_ptr];
  assign mispredict   = pop & (head.pred != resolveTaken);
  assign redirect_nxt = resolveTaken ? resolveTargetPC : head.pc + 32'd4;

  // Saturating 2-bit counter step for the retiring branch.
  assign head_ctr = bht[head.idx];
  always_comb begin
    head_ctr_nxt = head_ctr;
    if (resolveTaken && head_ctr != 2'b11)
      head_ctr_nxt = head_ctr + 2'b01;
    else if (!resolveTaken && head_ctr != 2'b00)
      head_ctr_nxt = head_ctr - 2'b01;
  end

  // Payload needs no reset: a stale slot is never read while count covers it.
  always_ff @(posedge clk) begin
    if (push)
      q[wr_ptr] <= '{pc: fetchPC, idx: fetch_idx, pred: predictTaken};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++)
        bht[i] <= 2'b01;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      flush      <= 1'b0;
      redirectPC <= '0;
    end else begin
      flush <= mispredict;
      if (mispredict)
        redirectPC <= redirect_nxt;
      if (pop)
        bht[head.idx] <= head_ctr_nxt;
      // A mispredict squashes everything younger, including this cycle's push.
      if (mispredict) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push)
          wr_ptr <= wr_ptr + PTR_ONE;
        if (pop)
          rd_ptr <= rd_ptr + PTR_ONE;
        case ({push, pop})
          2'b10:   count <= count + CNT_ONE;
          2'b01:   count <= count - CNT_ONE;
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor_ctrl.sv
// Directed bench for branch_predictor_ctrl: reset, training, queue full, mispredict clear, aliasing, PC wrap.
module tb_branch_predictor_ctrl;

  localparam logic [31:0] BR_INSTR = 32'h0000_0063;
  localparam logic [31:0] NB_INSTR = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetchValid;
  logic [31:0] fetchPC;
  logic [31:0] fetchInstr;
  logic        predictTaken;
  logic        fetchStall;
  logic        resolveValid;
  logic        resolveTaken;
  logic [31:0] resolveTargetPC;
  logic        flush;
  logic [31:0] redirectPC;

  int n_checks = 0;
  int n_fail   = 0;

  branch_predictor_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .fetchValid      (fetchValid),
    .fetchPC         (fetchPC),
    .fetchInstr      (fetchInstr),
    .predictTaken    (predictTaken),
    .fetchStall      (fetchStall),
    .resolveValid    (resolveValid),
    .resolveTaken    (resolveTaken),
    .resolveTargetPC (resolveTargetPC),
    .flush           (flush),
    .redirectPC      (redirectPC)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic fv, input logic [31:0] pc, input logic br,
                       input logic rv, input logic rt, input logic [31:0] tgt);
    fetchValid      = fv;
    fetchPC         = pc;
    fetchInstr      = br ? BR_INSTR : NB_INSTR;
    resolveValid    = rv;
    resolveTaken    = rt;
    resolveTargetPC = tgt;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    tick();

    // Reset state with a branch at 0x100 presented
    rst_n = 1'b1;
    drive(1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 32'h0);
    settle();
    check("rst_pred",   32'(predictTaken), 32'h0);
    check("rst_stall",  32'(fetchStall),   32'h0);
    check("rst_flush",  32'(flush),        32'h0);
    check("rst_redir",  redirectPC,        32'h0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    tick();
    check("rst_resolve_ok", 32'(flush), 32'h0);   // idx0 counter now 00

    // Training on 0x40 (idx 16)
    drive(1'b1, 32'h40, 1'b1, 1'b0, 1'b0, 32'h0);
    settle();
    check("train_pred0", 32'(predictTaken), 32'h0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h20);
    tick();
    check("train_flush1", 32'(flush), 32'h1);
    check("train_redir1", redirectPC, 32'h20);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    check("flush_one_cycle", 32'(flush), 32'h0);
    drive(1'b1, 32'h40, 1'b1, 1'b0, 1'b0, 32'h0);
    settle();
    check("train_pred1", 32'(predictTaken), 32'h1);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h20);
    tick();
    check("train_noflush", 32'(flush), 32'h0);
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'h40, 1'b1, 1'b0, 1'b0, 32'h0);
      tick();
      drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h20);
      tick();
      check("sat_noflush", 32'(flush), 32'h0);
    end
    drive(1'b1, 32'h40, 1'b0, 1'b0, 1'b0, 32'h0);
    settle();
    check("nonbranch_pred", 32'(predictTaken), 32'h0);
    drive(1'b0, 32'h40, 1'b1, 1'b0, 1'b0, 32'h0);
    settle();
    check("invalid_pred", 32'(predictTaken), 32'h0);
    drive(1'b1, 32'h40, 1'b1, 1'b0, 1'b0, 32'h0);
    settle();
    check("sat_pred", 32'(predictTaken), 32'h1);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h20);
    tick();
    check("nt_flush", 32'(flush), 32'h1);
    check("nt_redir", redirectPC, 32'h44);
    drive(1'b1, 32'h40, 1'b1, 1'b0, 1'b0, 32'h0);
    settle();
    check("sat_pred_holds", 32'(predictTaken), 32'h1);   // 11 -> 10
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();

    // Queue full (idx16 counter 10, predicts taken)
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h40, 1'b1, 1'b0, 1'b0, 32'h0);
      settle();
      check("fill_nostall", 32'(fetchStall), 32'h0);
      tick();
    end
    drive(1'b1, 32'h40, 1'b1, 1'b0, 1'b0, 32'h0);
    settle();
    check("full_stall", 32'(fetchStall), 32'h1);
    drive(1'b1, 32'h40, 1'b1, 1'b1, 1'b1, 32'h20);
    settle();
    check("full_pop_nostall", 32'(fetchStall), 32'h0);
    tick();
    check("full_pop_noflush", 32'(flush), 32'h0);
    drive(1'b1, 32'h40, 1'b1, 1'b0, 1'b0, 32'h0);
    settle();
    check("still_full", 32'(fetchStall), 32'h1);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h20);
    tick();
    check("drain_noflush", 32'(flush), 32'h0);

    // Mispredict with 3 queued while a new branch is fetched
    drive(1'b1, 32'h100, 1'b1, 1'b1, 1'b0, 32'h20);
    settle();
    check("clr_nostall", 32'(fetchStall), 32'h0);
    tick();
    check("clr_flush", 32'(flush), 32'h1);
    check("clr_redir", redirectPC, 32'h44);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h80);
    tick();
    check("spurious_ignored", 32'(flush), 32'h0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 32'h0);
      settle();
      check("clr_empty_fill", 32'(fetchStall), 32'h0);
      tick();
    end
    drive(1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 32'h0);
    settle();
    check("clr_refull", 32'(fetchStall), 32'h1);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
      tick();
      check("clr_drain", 32'(flush), 32'h0);
    end

    // Aliasing 0x40 / 0x140 (idx16 counter 10)
    drive(1'b1, 32'h40, 1'b1, 1'b0, 1'b0, 32'h0);
    settle();
    check("alias_pred_40", 32'(predictTaken), 32'h1);
    tick();
    drive(1'b1, 32'h140, 1'b1, 1'b1, 1'b0, 32'h20);
    settle();
    check("alias_old", 32'(predictTaken), 32'h1);
    tick();
    check("alias_flush", 32'(flush), 32'h1);
    check("alias_redir", redirectPC, 32'h44);
    drive(1'b1, 32'h140, 1'b1, 1'b0, 1'b0, 32'h0);
    settle();
    check("alias_new", 32'(predictTaken), 32'h0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h80);
    tick();
    check("flush_blocks_push", 32'(flush), 32'h0);

    // PC wrap at 0xFFFFFFFC (idx63 counter 01)
    drive(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0, 32'h0);
    settle();
    check("wrap_pred0", 32'(predictTaken), 32'h0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h200);
    tick();
    check("wrap_train_flush", 32'(flush), 32'h1);
    check("wrap_train_redir", redirectPC, 32'h200);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    drive(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0, 32'h0);
    settle();
    check("wrap_pred1", 32'(predictTaken), 32'h1);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h200);
    tick();
    check("wrap_flush", 32'(flush), 32'h1);
    check("wrap_redir", redirectPC, 32'h0);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();

    // Reset mid-operation drops in-flight entries without a flush
    drive(1'b1, 32'h40, 1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    rst_n = 1'b0;
    tick();
    check("midrst_flush", 32'(flush), 32'h0);
    check("midrst_redir", redirectPC, 32'h0);
    rst_n = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h80);
    tick();
    check("midrst_empty", 32'(flush), 32'h0);
    drive(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0, 32'h0);
    settle();
    check("midrst_bht_init", 32'(predictTaken), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
